// File: rtl/scope_trace_render_if.sv
// Scope renderer bus: VGA position/frame in, sample write port, trace-swap pulse and RGB pixels out.
// No latency of its own; wr_ready is the only backpressure signal (towards acquisition).
interface scope_trace_render_if;
    logic [9:0]  pix_h;
    logic [9:0]  pix_v;
    logic [31:0] frame_counter;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic        wr_ready;
    logic        wr_restart;
    logic        trace_swapped;
    logic [7:0]  r_pix_write_bus;
    logic [7:0]  g_pix_write_bus;
    logic [7:0]  b_pix_write_bus;

    modport master (
        output pix_h, pix_v, frame_counter, wr_valid, wr_data, wr_restart,
        input  wr_ready, trace_swapped, r_pix_write_bus, g_pix_write_bus, b_pix_write_bus
    );
    modport slave (
        input  pix_h, pix_v, frame_counter, wr_valid, wr_data, wr_restart,
        output wr_ready, trace_swapped, r_pix_write_bus, g_pix_write_bus, b_pix_write_bus
    );
endinterface

// File: rtl/scope_trace_render.sv
// Graticule + single-trace renderer fed from a frame-synchronously swapped double-buffered sample store.
// Pixel latency 2 cycles; wr_ready drops once the back bank is full and returns after the next swap.
module scope_trace_render #(
    parameter int         SCOPE_SCRN_XOFF  = 32,
    parameter int         SCOPE_SCRN_YOFF  = 32,
    parameter int         SCOPE_SCRN_XSIZE = 512,
    parameter int         SCOPE_SCRN_YSIZE = 384,
    parameter int         SCOPE_GRAT_SIZE  = 32,
    parameter logic [7:0] GRAT_LEVEL       = 8'h40,
    parameter logic [7:0] TRACE_G          = 8'hFF
) (
    input  logic                 drvclk_i,
    input  logic                 rst_i,
    scope_trace_render_if.slave  bus_io
);
    localparam int              AW       = $clog2(SCOPE_SCRN_XSIZE);
    localparam logic [9:0]      XOFF     = 10'(SCOPE_SCRN_XOFF);
    localparam logic [9:0]      YOFF     = 10'(SCOPE_SCRN_YOFF);
    localparam logic [9:0]      XSZ      = 10'(SCOPE_SCRN_XSIZE);
    localparam logic [9:0]      YSZ      = 10'(SCOPE_SCRN_YSIZE);
    localparam logic [9:0]      XMAX     = 10'(SCOPE_SCRN_XSIZE - 1);
    localparam logic [9:0]      YMAX     = 10'(SCOPE_SCRN_YSIZE - 1);
    localparam logic [9:0]      GMASK    = 10'(SCOPE_GRAT_SIZE - 1);
    localparam logic [8:0]      DMAX     = 9'(SCOPE_SCRN_YSIZE - 1);
    localparam logic [AW-1:0]   COL_LAST = AW'(SCOPE_SCRN_XSIZE - 1);

    typedef enum logic {FILL, FULL} fill_state_e;

    fill_state_e   state_q;
    logic [AW-1:0] col_q;
    logic          disp_bank_q, disp_valid_q, frame_q, trace_swapped_q;
    logic [8:0]    mem [0:2*SCOPE_SCRN_XSIZE-1];

    logic          frame_edge, wr_fire, swap;
    logic [8:0]    wr_clamped;
    logic          unused_fc;

    assign unused_fc       = ^bus_io.frame_counter[31:1];
    assign frame_edge      = bus_io.frame_counter[0] ^ frame_q;
    assign bus_io.wr_ready = (state_q == FILL);
    assign wr_fire         = bus_io.wr_valid & bus_io.wr_ready & ~bus_io.wr_restart & ~rst_i;
    // Swap needs back_full from before this cycle, so a final write on the edge cycle waits a frame.
    assign swap            = frame_edge & (state_q == FULL) & ~bus_io.wr_restart;
    assign wr_clamped      = (bus_io.wr_data > DMAX) ? DMAX : bus_io.wr_data;
    assign bus_io.trace_swapped = trace_swapped_q;

    always_ff @(posedge drvclk_i) begin
        if (rst_i) begin
            state_q         <= FILL;
            col_q           <= '0;
            disp_bank_q     <= 1'b0;
            disp_valid_q    <= 1'b0;
            frame_q         <= bus_io.frame_counter[0];
            trace_swapped_q <= 1'b0;
        end else begin
            frame_q         <= bus_io.frame_counter[0];
            trace_swapped_q <= swap;
            if (bus_io.wr_restart) begin
                col_q   <= '0;
                state_q <= FILL;
            end else begin
                case (state_q)
                    FILL: if (wr_fire) begin
                        col_q <= col_q + AW'(1);
                        if (col_q == COL_LAST) state_q <= FULL;
                    end
                    FULL: if (swap) begin
                        state_q      <= FILL;
                        disp_bank_q  <= ~disp_bank_q;
                        disp_valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // S1: window-relative coordinates and display-bank read.
    logic [9:0] lx_d, ly_d, lx_q, ly_q;
    logic       in_win_d, in_win_q;
    logic [8:0] rd_q, last_q;

    assign lx_d     = bus_io.pix_h - XOFF;
    assign ly_d     = bus_io.pix_v - YOFF;
    assign in_win_d = (bus_io.pix_h >= XOFF) & (lx_d < XSZ) & (bus_io.pix_v >= YOFF) & (ly_d < YSZ);

    always_ff @(posedge drvclk_i) begin
        if (wr_fire) mem[{~disp_bank_q, col_q}] <= wr_clamped;
        rd_q <= mem[{disp_bank_q, lx_d[AW-1:0]}];
    end

    always_ff @(posedge drvclk_i) begin
        if (rst_i) begin
            lx_q     <= '0;
            ly_q     <= '0;
            in_win_q <= 1'b0;
        end else begin
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            in_win_q <= in_win_d;
        end
    end

    // S2: vertical span between this sample and the previous one, so steep edges stay connected.
    logic [8:0] prev_d;
    logic [9:0] ya_d, yb_d, lo_d, hi_d;
    logic       trace_d, grat_d;
    logic [7:0] r_d, g_d, b_d, r_q, g_q, b_q;

    assign prev_d  = (lx_q == '0) ? rd_q : last_q;
    assign ya_d    = YMAX - {1'b0, rd_q};
    assign yb_d    = YMAX - {1'b0, prev_d};
    assign lo_d    = (ya_d < yb_d) ? ya_d : yb_d;
    assign hi_d    = (ya_d < yb_d) ? yb_d : ya_d;
    assign trace_d = disp_valid_q & (ly_q >= lo_d) & (ly_q <= hi_d);
    assign grat_d  = ((lx_q & GMASK) == '0) | ((ly_q & GMASK) == '0) | (lx_q == XMAX) | (ly_q == YMAX);

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (in_win_q) begin
            if (trace_d) begin
                g_d = TRACE_G;
            end else if (grat_d) begin
                r_d = GRAT_LEVEL;
                g_d = GRAT_LEVEL;
                b_d = GRAT_LEVEL;
            end
        end
    end

    always_ff @(posedge drvclk_i) begin
        if (rst_i) begin
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            last_q <= '0;
        end else begin
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            last_q <= rd_q;
        end
    end

    assign bus_io.r_pix_write_bus = r_q;
    assign bus_io.g_pix_write_bus = g_q;
    assign bus_io.b_pix_write_bus = b_q;
endmodule

// File: tb/tb_scope_trace_render.sv
// Bench for scope_trace_render: randomized samples checked against a frame-level trace/graticule model.
module tb_scope_trace_render;
    localparam int H0 = 28;
    localparam int NH = 520;

    logic drvclk = 1'b0;
    logic rst    = 1'b1;
    always #5 drvclk = ~drvclk;

    scope_trace_render_if bus();
    scope_trace_render dut (.drvclk_i(drvclk), .rst_i(rst), .bus_io(bus));

    int n_cmp = 0;
    int n_bad = 0;

    int m_disp[512];
    int m_back[512];
    int m_col;
    bit m_full, m_valid;
    logic [23:0] cap[NH];

    task automatic tick();
        @(posedge drvclk);
        #1;
    endtask

    function automatic logic [23:0] rgb();
        return {bus.r_pix_write_bus, bus.g_pix_write_bus, bus.b_pix_write_bus};
    endfunction

    function automatic void model_reset();
        m_col = 0; m_full = 0; m_valid = 0;
    endfunction

    function automatic void model_write(int d);
        if (!m_full) begin
            m_back[m_col] = (d > 383) ? 383 : d;
            m_col++;
            if (m_col == 512) begin m_col = 0; m_full = 1; end
        end
    endfunction

    // Expected pixel straight from the drawing rules: span fill, graticule, window.
    function automatic logic [23:0] exp_pix(int h, int v);
        int lx, ly, cur, prv, ya, yb, lo, hi;
        if (h < 32 || h >= 544 || v < 32 || v >= 416) return 24'h0;
        lx = h - 32; ly = v - 32;
        cur = m_disp[lx];
        prv = (lx == 0) ? cur : m_disp[lx-1];
        ya = 383 - cur; yb = 383 - prv;
        lo = (ya < yb) ? ya : yb; hi = (ya < yb) ? yb : ya;
        if (m_valid && ly >= lo && ly <= hi) return 24'h00FF00;
        if (lx % 32 == 0 || ly % 32 == 0 || lx == 511 || ly == 383) return 24'h404040;
        return 24'h0;
    endfunction

    task automatic push_sample(input int d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 9'(d);
        model_write(d);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic frame_step(output bit exp_sw, output logic got);
        exp_sw = m_full;
        if (m_full) begin m_disp = m_back; m_full = 0; m_valid = 1; end
        bus.frame_counter = bus.frame_counter + 32'd1;
        tick();
        got = bus.trace_swapped;
    endtask

    // Raster one row h=H0..H0+NH-1 and capture each pixel's output two cycles later.
    task automatic scan_row(input int v);
        for (int i = 0; i <= NH; i++) begin
            if (i < NH) begin bus.pix_h = 10'(H0 + i); bus.pix_v = 10'(v); end
            else begin bus.pix_h = '0; bus.pix_v = '0; end
            tick();
            if (i >= 1) cap[i-1] = rgb();
        end
    endtask

    task automatic test_reset();
        bit es; logic got; int rows[6];
        rows = '{31, 32, 33, 40, 415, 416};
        n_cmp++; if (rgb() !== 24'h0) begin n_bad++; $display("FAIL reset_rgb: got %h expected 000000", rgb()); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
        n_cmp++; if (bus.trace_swapped !== 1'b0) begin n_bad++; $display("FAIL reset_swapped: got %b expected 0", bus.trace_swapped); end
        frame_step(es, got);
        n_cmp++; if (got !== es) begin n_bad++; $display("FAIL reset_empty_edge: got %b expected %b", got, es); end
        for (int r = 0; r < 9; r++) begin
            int v;
            v = (r < 6) ? rows[r] : int'($urandom_range(28, 420));
            scan_row(v);
            for (int i = 0; i < NH; i++) begin
                n_cmp++; if (cap[i] !== exp_pix(H0+i, v)) begin n_bad++; $display("FAIL reset_pix(%0d,%0d): got %h expected %h", H0+i, v, cap[i], exp_pix(H0+i, v)); end
            end
            if (v == 32) begin
                n_cmp++; if (cap[32-H0] !== 24'h404040) begin n_bad++; $display("FAIL reset_corner_32_32: got %h expected 404040", cap[32-H0]); end
            end
            if (v == 33) begin
                n_cmp++; if (cap[33-H0] !== 24'h0) begin n_bad++; $display("FAIL reset_33_33: got %h expected 000000", cap[33-H0]); end
            end
            if (v == 40) begin
                n_cmp++; if (cap[31-H0] !== 24'h0) begin n_bad++; $display("FAIL reset_31_40: got %h expected 000000", cap[31-H0]); end
            end
        end
    endtask

    task automatic test_flat();
        bit es; logic got; int greens; int rows[5];
        rows = '{314, 315, 316, 32, 415};
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL flat_ready_start: got %b expected 1", bus.wr_ready); end
        for (int i = 0; i < 512; i++) push_sample(100);
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL flat_ready_full: got %b expected 0", bus.wr_ready); end
        frame_step(es, got);
        n_cmp++; if (got !== 1'b1 || es !== 1'b1) begin n_bad++; $display("FAIL flat_swap_pulse: got %b expected 1", got); end
        tick();
        n_cmp++; if (bus.trace_swapped !== 1'b0) begin n_bad++; $display("FAIL flat_pulse_once: got %b expected 0", bus.trace_swapped); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL flat_ready_back: got %b expected 1", bus.wr_ready); end
        for (int r = 0; r < 5; r++) begin
            scan_row(rows[r]);
            greens = 0;
            for (int i = 0; i < NH; i++) begin
                if (cap[i] === 24'h00FF00) greens++;
                n_cmp++; if (cap[i] !== exp_pix(H0+i, rows[r])) begin n_bad++; $display("FAIL flat_pix(%0d,%0d): got %h expected %h", H0+i, rows[r], cap[i], exp_pix(H0+i, rows[r])); end
            end
            n_cmp++; if (greens !== ((rows[r] == 315) ? 512 : 0)) begin n_bad++; $display("FAIL flat_green_count row %0d: got %0d expected %0d", rows[r], greens, (rows[r] == 315) ? 512 : 0); end
        end
    endtask

    task automatic test_ramp();
        bit es; logic got; int rows[6];
        rows = '{31, 32, 33, 200, 415, 416};
        for (int i = 0; i < 512; i++) push_sample((i % 2 == 0) ? 0 : 383);
        frame_step(es, got);
        n_cmp++; if (got !== es) begin n_bad++; $display("FAIL ramp_swap: got %b expected %b", got, es); end
        for (int r = 0; r < 6; r++) begin
            scan_row(rows[r]);
            for (int i = 0; i < NH; i++) begin
                n_cmp++; if (cap[i] !== exp_pix(H0+i, rows[r])) begin n_bad++; $display("FAIL ramp_pix(%0d,%0d): got %h expected %h", H0+i, rows[r], cap[i], exp_pix(H0+i, rows[r])); end
            end
            if (rows[r] == 200) begin
                n_cmp++; if (cap[32-H0] === 24'h00FF00) begin n_bad++; $display("FAIL ramp_col0_row200: got %h expected not green", cap[32-H0]); end
            end
            if (rows[r] == 415) begin
                n_cmp++; if (cap[32-H0] !== 24'h00FF00) begin n_bad++; $display("FAIL ramp_col0_row415: got %h expected 00ff00", cap[32-H0]); end
            end
        end
    endtask

    task automatic test_edge_write();
        bit es; logic got; int d; int v;
        for (int i = 0; i < 511; i++) push_sample($urandom_range(0, 383));
        d = $urandom_range(0, 383);
        bus.wr_valid = 1'b1; bus.wr_data = 9'(d);
        bus.frame_counter = bus.frame_counter + 32'd1;
        es = m_full;
        model_write(d);
        tick();
        bus.wr_valid = 1'b0;
        n_cmp++; if (bus.trace_swapped !== es) begin n_bad++; $display("FAIL edge_same_cycle_swap: got %b expected %b", bus.trace_swapped, es); end
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL edge_ready_after: got %b expected 0", bus.wr_ready); end
        repeat (20) tick();
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL edge_ready_hold: got %b expected 0", bus.wr_ready); end
        frame_step(es, got);
        n_cmp++; if (got !== 1'b1 || es !== 1'b1) begin n_bad++; $display("FAIL edge_next_swap: got %b expected 1", got); end
        for (int r = 0; r < 3; r++) begin
            v = $urandom_range(30, 418);
            scan_row(v);
            for (int i = 0; i < NH; i++) begin
                n_cmp++; if (cap[i] !== exp_pix(H0+i, v)) begin n_bad++; $display("FAIL edge_pix(%0d,%0d): got %h expected %h", H0+i, v, cap[i], exp_pix(H0+i, v)); end
            end
        end
    endtask

    task automatic test_restart();
        bit es; logic got; int rows[2];
        rows = '{414, 415};
        for (int i = 0; i < 200; i++) push_sample($urandom_range(1, 383));
        bus.wr_restart = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 9'd300;
        model_reset(); m_valid = 1;
        tick();
        bus.wr_restart = 1'b0; bus.wr_valid = 1'b0;
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b expected 1", bus.wr_ready); end
        for (int i = 0; i < 512; i++) push_sample(0);
        frame_step(es, got);
        n_cmp++; if (got !== 1'b1 || es !== 1'b1) begin n_bad++; $display("FAIL restart_swap: got %b expected 1", got); end
        // Fill again, then let a restart collide with the frame edge.
        for (int i = 0; i < 512; i++) push_sample($urandom_range(0, 383));
        bus.wr_restart = 1'b1;
        bus.frame_counter = bus.frame_counter + 32'd1;
        m_col = 0; m_full = 0;
        tick();
        bus.wr_restart = 1'b0;
        n_cmp++; if (bus.trace_swapped !== 1'b0) begin n_bad++; $display("FAIL restart_beats_swap: got %b expected 0", bus.trace_swapped); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL restart_swap_ready: got %b expected 1", bus.wr_ready); end
        frame_step(es, got);
        n_cmp++; if (got !== es) begin n_bad++; $display("FAIL restart_idle_edge: got %b expected %b", got, es); end
        for (int r = 0; r < 2; r++) begin
            scan_row(rows[r]);
            for (int i = 0; i < NH; i++) begin
                n_cmp++; if (cap[i] !== exp_pix(H0+i, rows[r])) begin n_bad++; $display("FAIL restart_pix(%0d,%0d): got %h expected %h", H0+i, rows[r], cap[i], exp_pix(H0+i, rows[r])); end
            end
        end
    endtask

    task automatic test_clamp_reset();
        bit es; logic got;
        for (int i = 0; i < 512; i++) push_sample(511);
        frame_step(es, got);
        n_cmp++; if (got !== es) begin n_bad++; $display("FAIL clamp_swap: got %b expected %b", got, es); end
        for (int r = 32; r <= 33; r++) begin
            scan_row(r);
            for (int i = 0; i < NH; i++) begin
                n_cmp++; if (cap[i] !== exp_pix(H0+i, r)) begin n_bad++; $display("FAIL clamp_pix(%0d,%0d): got %h expected %h", H0+i, r, cap[i], exp_pix(H0+i, r)); end
            end
        end
        bus.pix_h = 10'd40; bus.pix_v = 10'd32;
        repeat (3) tick();
        n_cmp++; if (rgb() !== exp_pix(40, 32)) begin n_bad++; $display("FAIL clamp_pre_reset: got %h expected %h", rgb(), exp_pix(40, 32)); end
        rst = 1'b1;
        tick();
        n_cmp++; if (rgb() !== 24'h0) begin n_bad++; $display("FAIL midframe_reset_rgb: got %h expected 000000", rgb()); end
        rst = 1'b0;
        model_reset();
        repeat (3) tick();
        n_cmp++; if (rgb() !== exp_pix(40, 32)) begin n_bad++; $display("FAIL post_reset_no_trace: got %h expected %h", rgb(), exp_pix(40, 32)); end
        frame_step(es, got);
        n_cmp++; if (got !== es) begin n_bad++; $display("FAIL post_reset_edge: got %b expected %b", got, es); end
        scan_row(32);
        for (int i = 0; i < NH; i++) begin
            n_cmp++; if (cap[i] !== exp_pix(H0+i, 32)) begin n_bad++; $display("FAIL post_reset_pix(%0d,32): got %h expected %h", H0+i, cap[i], exp_pix(H0+i, 32)); end
        end
    endtask

    task automatic test_random();
        bit es, vld, tog; int d, v, swaps;
        for (int it = 0; it < 3; it++) begin
            swaps = 0;
            for (int c = 0; c < 4000 && swaps < 1; c++) begin
                vld = ($urandom_range(0, 3) != 0);
                tog = ($urandom_range(0, 63) == 0);
                d = $urandom_range(0, 511);
                n_cmp++; if (bus.wr_ready !== ~m_full) begin n_bad++; $display("FAIL rand_ready: got %b expected %b", bus.wr_ready, ~m_full); end
                bus.wr_valid = vld; bus.wr_data = 9'(d);
                if (tog) bus.frame_counter = bus.frame_counter + 32'd1;
                es = tog && m_full;
                if (es) begin m_disp = m_back; m_full = 0; m_valid = 1; end
                else if (vld) model_write(d);
                tick();
                bus.wr_valid = 1'b0;
                n_cmp++; if (bus.trace_swapped !== es) begin n_bad++; $display("FAIL rand_swap: got %b expected %b", bus.trace_swapped, es); end
                if (es) swaps++;
            end
            for (int r = 0; r < 3; r++) begin
                v = $urandom_range(30, 418);
                scan_row(v);
                for (int i = 0; i < NH; i++) begin
                    n_cmp++; if (cap[i] !== exp_pix(H0+i, v)) begin n_bad++; $display("FAIL rand_pix(%0d,%0d): got %h expected %h", H0+i, v, cap[i], exp_pix(H0+i, v)); end
                end
            end
        end
    endtask

    initial begin
        bus.pix_h = '0; bus.pix_v = '0; bus.frame_counter = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_restart = 1'b0;
        for (int i = 0; i < 512; i++) begin m_disp[i] = 0; m_back[i] = 0; end
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_flat();
        test_ramp();
        test_edge_write();
        test_restart();
        test_clamp_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
